// File: rtl/key_hash_pkg.sv
// Shared helpers for the key fold hash block.
// Chunk count, default seeds, idle output pattern.
package key_hash_pkg;

  localparam int MAX_OUT_W = 128 + 4 * 16;

  localparam logic [31:0] DEFAULT_SEEDS = {16'h0F0F, 16'h0000};

  function automatic int chunk_count(input int key_w, input int hash_w);
    return (key_w + hash_w - 1) / hash_w;
  endfunction

  // Key field zero, every hash lane all-ones; caller trims to width.
  function automatic logic [MAX_OUT_W-1:0] idle_pattern(
    input int hash_w,
    input int num_hash
  );
    logic [MAX_OUT_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      if (i < hash_w * num_hash) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/key_fold.sv
// XOR-fold of a key into one HASH_W chunk (combinational).
// Ports: key (KEY_W) in, fold (HASH_W) out.
module key_fold
  import key_hash_pkg::*;
#(
  parameter int KEY_W  = 32,
  parameter int HASH_W = 12
) (
  input  logic [KEY_W-1:0]  key,
  output logic [HASH_W-1:0] fold
);

  localparam int NCH   = chunk_count(KEY_W, HASH_W);
  localparam int EXT_W = NCH * HASH_W;

  logic [EXT_W-1:0] key_ext;

  assign key_ext = EXT_W'(key);

  always_comb begin
    fold = '0;
    for (int c = 0; c < NCH; c++) begin
      fold = fold ^ key_ext[c*HASH_W +: HASH_W];
    end
  end

endmodule

// File: rtl/key_fold_hash.sv
// Two-stage flow-key hasher: fold in stage 1, lanes in stage 2.
// Ports: clk, reset (async low), key_in_* / hash_out_* handshakes, key_count.
module key_fold_hash
  import key_hash_pkg::*;
#(
  parameter int KEY_W    = 32,
  parameter int HASH_W   = 12,
  parameter int NUM_HASH = 2,
  parameter logic [NUM_HASH*16-1:0] SEEDS = DEFAULT_SEEDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_in_wr,
  input  logic [KEY_W-1:0]                key_in,
  input  logic                            key_in_mode,
  output logic                            key_in_rdy,
  output logic                            hash_out_wr,
  output logic [KEY_W+NUM_HASH*HASH_W-1:0] hash_out,
  input  logic                            hash_out_rdy,
  output logic [31:0]                     key_count
);

  localparam int LANES_W = NUM_HASH * HASH_W;
  localparam int OUT_W   = KEY_W + LANES_W;
  localparam logic [OUT_W-1:0] IDLE =
    OUT_W'(idle_pattern(HASH_W, NUM_HASH));

  logic               stall;
  logic               xfer_out;
  logic [HASH_W-1:0]  fold;
  logic               s1_vld;
  logic [KEY_W-1:0]   s1_key;
  logic               s1_mode;
  logic [HASH_W-1:0]  s1_fold;
  logic [LANES_W-1:0] lanes;
  logic [31:0]        cnt_q;

  // One stall term freezes the whole pipe.
  assign stall      = hash_out_wr & ~hash_out_rdy;
  assign key_in_rdy = ~stall;
  assign xfer_out   = hash_out_wr & hash_out_rdy;
  assign key_count  = cnt_q;

  key_fold #(
    .KEY_W  (KEY_W),
    .HASH_W (HASH_W)
  ) u_fold (
    .key  (key_in),
    .fold (fold)
  );

  for (genvar i = 0; i < NUM_HASH; i++) begin : g_lane
    logic [HASH_W-1:0] rot;
    // For i = 0 the right shift by HASH_W yields zero.
    assign rot = (s1_fold << i) | (s1_fold >> (HASH_W - i));
    assign lanes[i*HASH_W +: HASH_W] =
      s1_mode ? (rot ^ SEEDS[i*16 +: HASH_W]) : s1_fold;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld      <= 1'b0;
      s1_key      <= '0;
      s1_mode     <= 1'b0;
      s1_fold     <= '0;
      hash_out_wr <= 1'b0;
      hash_out    <= IDLE;
      cnt_q       <= '0;
    end else begin
      if (xfer_out) cnt_q <= cnt_q + 32'd1;
      if (!stall) begin
        s1_vld <= key_in_wr;
        if (key_in_wr) begin
          s1_key  <= key_in;
          s1_mode <= key_in_mode;
          s1_fold <= fold;
        end
        hash_out_wr <= s1_vld;
        hash_out    <= s1_vld ? {s1_key, lanes} : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_key_fold_hash.sv
// Directed bench for key_fold_hash with hand-computed vectors.
// KEY_W=32, HASH_W=12, NUM_HASH=2, SEEDS={0FFF,0000}.
module tb_key_fold_hash;

  logic        clk;
  logic        reset;
  logic        key_in_wr;
  logic [31:0] key_in;
  logic        key_in_mode;
  logic        key_in_rdy;
  logic        hash_out_wr;
  logic [55:0] hash_out;
  logic        hash_out_rdy;
  logic [31:0] key_count;

  int errors = 0;
  int checks = 0;

  key_fold_hash #(
    .KEY_W    (32),
    .HASH_W   (12),
    .NUM_HASH (2),
    .SEEDS    ({16'h0FFF, 16'h0000})
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in_wr    (key_in_wr),
    .key_in       (key_in),
    .key_in_mode  (key_in_mode),
    .key_in_rdy   (key_in_rdy),
    .hash_out_wr  (hash_out_wr),
    .hash_out     (hash_out),
    .hash_out_rdy (hash_out_rdy),
    .key_count    (key_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [55:0] IDLE = {32'h0, 12'hFFF, 12'hFFF};

  logic [31:0] kq [5];
  logic [55:0] eq [5];
  logic [55:0] held;
  int sent;
  int got;

  initial begin
    kq[0] = 32'h0000_0001; eq[0] = {32'h0000_0001, 12'h001, 12'h001};
    kq[1] = 32'h0000_0FFF; eq[1] = {32'h0000_0FFF, 12'hFFF, 12'hFFF};
    kq[2] = 32'hFFFF_FFFF; eq[2] = {32'hFFFF_FFFF, 12'h0FF, 12'h0FF};
    kq[3] = 32'h8000_0000; eq[3] = {32'h8000_0000, 12'h080, 12'h080};
    kq[4] = 32'h0012_3456; eq[4] = {32'h0012_3456, 12'h575, 12'h575};
    held = '0;

    reset        = 1'b0;
    key_in_wr    = 1'b0;
    key_in       = '0;
    key_in_mode  = 1'b0;
    hash_out_rdy = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr", hash_out_wr, 0);
    chk("rst_out", hash_out, IDLE);
    chk("rst_cnt", key_count, 0);

    // First key on first edge out of reset, plain fold
    reset       = 1'b1;
    key_in_wr   = 1'b1;
    key_in      = 32'h1234_5678;
    key_in_mode = 1'b0;
    @(negedge clk);
    key_in_wr = 1'b0;
    chk("lat_wr_early", hash_out_wr, 0);
    @(negedge clk);
    chk("plain_wr", hash_out_wr, 1);
    chk("plain_out", hash_out, {32'h1234_5678, 12'h52F, 12'h52F});

    // Seeded keys back to back
    key_in_wr   = 1'b1;
    key_in      = 32'h1234_5678;
    key_in_mode = 1'b1;
    @(negedge clk);
    key_in      = 32'hFFFF_FFFF;
    chk("cnt_one", key_count, 1);
    @(negedge clk);
    key_in_wr = 1'b0;
    chk("seed_out_a", hash_out, {32'h1234_5678, 12'h5A1, 12'h52F});
    @(negedge clk);
    chk("seed_out_b", hash_out, {32'hFFFF_FFFF, 12'hE01, 12'h0FF});
    @(negedge clk);
    chk("idle_wr", hash_out_wr, 0);
    chk("idle_out", hash_out, IDLE);
    chk("cnt_three", key_count, 3);

    // Clear count, then backpressure stream
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      hash_out_rdy = !(c >= 3 && c <= 6);
      key_in_wr    = (sent < 5);
      key_in       = kq[(sent < 5) ? sent : 0];
      key_in_mode  = 1'b0;
      #1;
      if (c >= 3 && c <= 6) chk("stall_rdy", key_in_rdy, 0);
      if (c == 3) held = hash_out;
      if (c > 3 && c <= 6) chk("stall_hold", hash_out, held);
      if (hash_out_wr && hash_out_rdy) begin
        if (got < 5) chk("stream_out", hash_out, eq[got]);
        else chk("stream_extra", got, 4);
        got++;
      end
      if (key_in_wr && key_in_rdy) sent++;
    end
    key_in_wr    = 1'b0;
    hash_out_rdy = 1'b1;
    chk("stream_got", got, 5);
    chk("stream_cnt", key_count, 5);

    // Reset with two keys in flight
    @(negedge clk);
    key_in_wr = 1'b1;
    key_in    = 32'hDEAD_BEEF;
    @(negedge clk);
    key_in    = 32'hCAFE_F00D;
    @(negedge clk);
    key_in_wr = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mid_rst_wr", hash_out_wr, 0);
    chk("mid_rst_out", hash_out, IDLE);
    chk("mid_rst_cnt", key_count, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale_wr", hash_out_wr, 0);
      chk("no_stale_cnt", key_count, 0);
    end

    // Counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", key_count, 32'hFFFF_FFFF);
    key_in_wr   = 1'b1;
    key_in      = 32'hA5A5_A5A5;
    key_in_mode = 1'b0;
    @(negedge clk);
    key_in_wr = 1'b0;
    @(negedge clk);
    chk("wrap_hold", key_count, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_zero", key_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
